ex_stage_unit: RTL and testbench
================================

Name: ex_stage_unit

Overview:
- Execute-stage core of the 5-stage pipelined RV32I processor.
- Combines three functions:
  - load-use hazard detection for the ID stage;
  - forwarding-aware ALU operand selection;
  - the integer ALU with branch-condition evaluation.
- ALU result, branch flag and store data are registered on the clock edge, forming the EX-side half of the EX/MEM boundary.
- Stall indication is combinational.

Parameters:
- XLEN, 32, datapath width.
- REG_AW, 5, register-index width.

Ports:
- clock  in  1  pipeline clock; all state updates on rising edge.
- clear  in  1  synchronous active-low reset.
- ex_mem_read  in  1  instruction in EX is a load.
- ex_rd  in  REG_AW  destination of instruction in EX.
- id_rs1, id_rs2  in  REG_AW  sources of instruction in ID.
- not_stall  out  1  0 = hold PC and IF/ID, bubble into ID/EX (combinational).
- ex_data_a, ex_data_b  in  XLEN  register-file operands latched in ID/EX.
- ex_imm  in  XLEN  sign-extended immediate.
- mem_alu_result  in  XLEN  ALU result held in MEM stage.
- wb_data_d  in  XLEN  write-back data.
- forward_a, forward_b  in  2  forwarding selects.
- alu_src  in  1  1 = operand B is immediate.
- alu_op  in  3  ALU operation class.
- func  in  4  {instr[30], funct3}.
- alu_result_q  out  XLEN  registered ALU result.
- branch_q  out  1  registered branch condition.
- store_data_q  out  XLEN  registered forwarded rs2 value, for stores.

Behaviour:
- Hazard detection:
  - not_stall = 0 iff ex_mem_read=1, ex_rd != 0, and (ex_rd == id_rs1 or ex_rd == id_rs2).
  - Otherwise not_stall = 1.
  - Purely combinational; unaffected by clear.
- Operand A forwarding:
  - forward_a 00 → ex_data_a; 10 → mem_alu_result; 01 → wb_data_d; 11 → ex_data_a.
  - MEM takes priority by encoding; the encoding is produced externally.
- Operand B forwarding:
  - fwdB is selected from ex_data_b by forward_b, using the same encoding as A.
  - aluB = alu_src ? ex_imm : fwdB.
  - store_data source is always fwdB, never the immediate.
- alu_op 000 (load/store/JAL address): result = A+B; branch = 0.
- alu_op 001 (branch): result = A−B. branch flag by funct3:
  - 000 EQ; 001 NE;
  - 100 signed LT; 101 signed GE;
  - 110 unsigned LT; 111 unsigned GE;
  - 010/011 → 0.
- alu_op 010 (R-type), by funct3 (func[3] = instr[30]):
  - 000: ADD, or SUB if func[3].
  - 001: SLL.
  - 010: SLT (signed).
  - 011: SLTU.
  - 100: XOR.
  - 101: SRL, or SRA if func[3].
  - 110: OR.
  - 111: AND.
- alu_op 011 (I-type): same table as 010, except funct3=000 is always ADD (func[3] ignored). func[3] is honoured only for funct3=101 (SRAI).
- alu_op 100 (LUI): result = B.
- alu_op 101–111: result = A+B, branch = 0.
- Arithmetic rules:
  - Shift amount = aluB[4:0].
  - SLT/SLTU produce 32'h0 or 32'h1.
  - Add/sub wrap modulo 2^32; no overflow trap.
  - branch = 0 for every alu_op other than 001.
- Registers:
  - On each rising clock edge with clear=1, capture result, branch and fwdB into alu_result_q, branch_q and store_data_q.
  - clear=0 at an edge forces all three to 0, overriding the capture, including mid-operation.
- Latency:
  - Operand-to-registered-output latency is 1 cycle.
  - Forwarded values are used in the same cycle they are presented.

Optional Feature:
- Macro EXU_STALL_COUNTER_EN.
- When defined:
  - adds output stall_count [31:0];
  - increments on each rising edge with clear=1 and not_stall=0;
  - wraps from 32'hFFFFFFFF to 0;
  - cleared to 0 when clear=0.
- When undefined:
  - the port and the counter are absent;
  - all other behaviour is identical.

Decomposition:
- Shared package ex_pkg holds:
  - ALU_OP_* constants for the 3-bit class codes;
  - FWD_ID/FWD_MEM/FWD_WB constants for the select codes;
  - funct3 constants for ALU and branch operations;
  - XLEN.
- One natural sub-module: ex_alu, the combinational ALU with branch compare, instantiated once.
- Hazard logic and operand muxes stay inline.

Test Plan:
- Load-use stall:
  - ex_mem_read=1, ex_rd=5, id_rs1=5 → not_stall=0.
  - id_rs1=id_rs2=6 → not_stall=1.
  - ex_rd=0 with id_rs1=0 → not_stall=1.
- Forwarding:
  - ex_data_a=1, mem_alu_result=7, wb_data_d=9, alu_op=000, alu_src=1, ex_imm=2.
  - forward_a=10 → alu_result_q=9 after one edge.
  - forward_a=01 → alu_result_q=11.
- Branch:
  - alu_op=001, A=1, B=2.
  - func=0001 (BNE) → branch_q=1.
  - func=0000 → branch_q=0.
  - A=32'hFFFFFFFF, B=1, func=0110 (BLTU) → branch_q=0.
  - func=0100 (BLT) → branch_q=1.
- R/I-type:
  - SUB (alu_op=010, func=1000): 5−7 → 32'hFFFFFFFE.
  - SRA (func=1101): 32'h80000000 >> 4 → 32'hF8000000.
  - ADDI (alu_op=011, func=1000, imm=3, A=4) → 7.
- Store data:
  - alu_src=1, forward_b=10, mem_alu_result=32'hABCD → store_data_q=32'hABCD, with aluB equal to the immediate.
- Reset:
  - Hold clear=0 across an edge with non-zero operands → alu_result_q, branch_q, store_data_q (and stall_count if enabled) all 0.

Source files
------------

// File: rtl/ex_pkg.sv
// ex_pkg: shared constants for the execute stage (ALU classes, forward selects, funct3 codes).
package ex_pkg;
    localparam int XLEN   = 32;
    localparam int REG_AW = 5;

    localparam logic [2:0] ALU_OP_ADDR   = 3'b000;
    localparam logic [2:0] ALU_OP_BRANCH = 3'b001;
    localparam logic [2:0] ALU_OP_RTYPE  = 3'b010;
    localparam logic [2:0] ALU_OP_ITYPE  = 3'b011;
    localparam logic [2:0] ALU_OP_LUI    = 3'b100;

    localparam logic [1:0] FWD_ID  = 2'b00;
    localparam logic [1:0] FWD_MEM = 2'b10;
    localparam logic [1:0] FWD_WB  = 2'b01;

    localparam logic [2:0] F3_ADD  = 3'b000;
    localparam logic [2:0] F3_SLL  = 3'b001;
    localparam logic [2:0] F3_SLT  = 3'b010;
    localparam logic [2:0] F3_SLTU = 3'b011;
    localparam logic [2:0] F3_XOR  = 3'b100;
    localparam logic [2:0] F3_SR   = 3'b101;
    localparam logic [2:0] F3_OR   = 3'b110;
    localparam logic [2:0] F3_AND  = 3'b111;

    localparam logic [2:0] BR_EQ  = 3'b000;
    localparam logic [2:0] BR_NE  = 3'b001;
    localparam logic [2:0] BR_LT  = 3'b100;
    localparam logic [2:0] BR_GE  = 3'b101;
    localparam logic [2:0] BR_LTU = 3'b110;
    localparam logic [2:0] BR_GEU = 3'b111;
endpackage

// File: rtl/ex_stage_unit_if.sv
// ex_stage_unit_if: hazard, operand and EX/MEM result signals of the execute stage.
interface ex_stage_unit_if #(parameter int XLEN = 32, parameter int REG_AW = 5);
    logic              ex_mem_read;
    logic [REG_AW-1:0] ex_rd;
    logic [REG_AW-1:0] id_rs1;
    logic [REG_AW-1:0] id_rs2;
    logic              not_stall;
    logic [XLEN-1:0]   ex_data_a;
    logic [XLEN-1:0]   ex_data_b;
    logic [XLEN-1:0]   ex_imm;
    logic [XLEN-1:0]   mem_alu_result;
    logic [XLEN-1:0]   wb_data_d;
    logic [1:0]        forward_a;
    logic [1:0]        forward_b;
    logic              alu_src;
    logic [2:0]        alu_op;
    logic [3:0]        func;
    logic [XLEN-1:0]   alu_result_q;
    logic              branch_q;
    logic [XLEN-1:0]   store_data_q;

    modport master (
        output ex_mem_read, ex_rd, id_rs1, id_rs2, ex_data_a, ex_data_b, ex_imm,
               mem_alu_result, wb_data_d, forward_a, forward_b, alu_src, alu_op, func,
        input  not_stall, alu_result_q, branch_q, store_data_q
    );
    modport slave (
        input  ex_mem_read, ex_rd, id_rs1, id_rs2, ex_data_a, ex_data_b, ex_imm,
               mem_alu_result, wb_data_d, forward_a, forward_b, alu_src, alu_op, func,
        output not_stall, alu_result_q, branch_q, store_data_q
    );
endinterface

// File: rtl/ex_alu.sv
// ex_alu: combinational RV32I integer ALU with branch-condition evaluation.
module ex_alu
    import ex_pkg::*;
#(
    parameter int W = XLEN
) (
    input  logic [2:0]   alu_op,
    input  logic [3:0]   func,
    input  logic [W-1:0] a,
    input  logic [W-1:0] b,
    output logic [W-1:0] result,
    output logic         branch
);
    logic [2:0]   f3;
    logic [4:0]   shamt;
    logic         alt;
    logic         lt_s;
    logic         lt_u;
    logic [W-1:0] arith;

    assign f3    = func[2:0];
    assign shamt = b[4:0];
    assign lt_s  = $signed(a) < $signed(b);
    assign lt_u  = a < b;
    // instr[30] selects SUB only for R-type; shifts honour it for both R and I forms
    assign alt   = func[3] && (alu_op == ALU_OP_RTYPE || f3 == F3_SR);

    always_comb begin
        arith = a + b;
        case (f3)
            F3_ADD:  arith = alt ? a - b : a + b;
            F3_SLL:  arith = a << shamt;
            F3_SLT:  arith = {{(W-1){1'b0}}, lt_s};
            F3_SLTU: arith = {{(W-1){1'b0}}, lt_u};
            F3_XOR:  arith = a ^ b;
            F3_SR:   arith = alt ? W'($signed(a) >>> shamt) : a >> shamt;
            F3_OR:   arith = a | b;
            default: arith = a & b;
        endcase
    end

    always_comb begin
        result = a + b;
        branch = 1'b0;
        case (alu_op)
            ALU_OP_BRANCH: begin
                result = a - b;
                case (f3)
                    BR_EQ:   branch = a == b;
                    BR_NE:   branch = a != b;
                    BR_LT:   branch = lt_s;
                    BR_GE:   branch = !lt_s;
                    BR_LTU:  branch = lt_u;
                    BR_GEU:  branch = !lt_u;
                    default: branch = 1'b0;
                endcase
            end
            ALU_OP_RTYPE, ALU_OP_ITYPE: result = arith;
            ALU_OP_LUI:                 result = b;
            default:                    result = a + b;
        endcase
    end
endmodule

// File: rtl/ex_stage_unit.sv
// ex_stage_unit: EX stage with load-use hazard detection, operand forwarding, ALU and EX/MEM registers.
// Define EXU_STALL_COUNTER_EN to add the stall_count output.
module ex_stage_unit
    import ex_pkg::*;
#(
    parameter int XLEN   = ex_pkg::XLEN,
    parameter int REG_AW = ex_pkg::REG_AW
) (
    input  logic        clock,
    input  logic        clear,
`ifdef EXU_STALL_COUNTER_EN
    output logic [31:0] stall_count,
`endif
    ex_stage_unit_if.slave bus
);
    logic [XLEN-1:0] fwd_a;
    logic [XLEN-1:0] fwd_b;
    logic [XLEN-1:0] alu_b;
    logic [XLEN-1:0] result;
    logic            branch;

    assign bus.not_stall = !(bus.ex_mem_read && bus.ex_rd != '0 &&
                             (bus.ex_rd == bus.id_rs1 || bus.ex_rd == bus.id_rs2));

    // select code 11 is unused and falls back to the register-file value
    assign fwd_a = bus.forward_a == FWD_MEM ? bus.mem_alu_result :
                   bus.forward_a == FWD_WB  ? bus.wb_data_d : bus.ex_data_a;
    assign fwd_b = bus.forward_b == FWD_MEM ? bus.mem_alu_result :
                   bus.forward_b == FWD_WB  ? bus.wb_data_d : bus.ex_data_b;
    assign alu_b = bus.alu_src ? bus.ex_imm : fwd_b;

    ex_alu #(.W(XLEN)) u_alu (
        .alu_op (bus.alu_op),
        .func   (bus.func),
        .a      (fwd_a),
        .b      (alu_b),
        .result (result),
        .branch (branch)
    );

    always_ff @(posedge clock) begin
        if (!clear) begin
            bus.alu_result_q <= '0;
            bus.branch_q     <= 1'b0;
            bus.store_data_q <= '0;
        end else begin
            bus.alu_result_q <= result;
            bus.branch_q     <= branch;
            bus.store_data_q <= fwd_b;
        end
    end

`ifdef EXU_STALL_COUNTER_EN
    always_ff @(posedge clock) begin
        if (!clear) stall_count <= '0;
        else if (!bus.not_stall) stall_count <= stall_count + 32'd1;
    end
`endif
endmodule

// File: tb/tb_ex_stage_unit.sv
// tb_ex_stage_unit: directed self-checking bench for ex_stage_unit.
module tb_ex_stage_unit;
    logic clock = 1'b0;
    logic clear = 1'b0;
    int   passed = 0;
    int   total  = 0;

    ex_stage_unit_if #(.XLEN(32), .REG_AW(5)) bus ();
`ifdef EXU_STALL_COUNTER_EN
    logic [31:0] stall_count;
    ex_stage_unit dut (.clock(clock), .clear(clear), .stall_count(stall_count), .bus(bus));
`else
    ex_stage_unit dut (.clock(clock), .clear(clear), .bus(bus));
`endif

    always #5 clock = ~clock;

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    task automatic drive(input logic [2:0] op, input logic [3:0] fn, input logic [31:0] a,
                         input logic [31:0] b, input logic [31:0] imm, input logic src,
                         input logic [1:0] fa, input logic [1:0] fb);
        bus.alu_op = op; bus.func = fn; bus.ex_data_a = a; bus.ex_data_b = b;
        bus.ex_imm = imm; bus.alu_src = src; bus.forward_a = fa; bus.forward_b = fb;
    endtask

    task automatic hazard(input logic rd_load, input logic [4:0] rd, input logic [4:0] rs1,
                          input logic [4:0] rs2);
        bus.ex_mem_read = rd_load; bus.ex_rd = rd; bus.id_rs1 = rs1; bus.id_rs2 = rs2;
        #1;
    endtask

    task automatic chk_res(input string name, input logic [31:0] exp);
        total++;
        if (bus.alu_result_q !== exp)
            $display("FAIL %s: alu_result_q got %h expected %h", name, bus.alu_result_q, exp);
        else passed++;
    endtask

    task automatic chk_br(input string name, input logic exp);
        total++;
        if (bus.branch_q !== exp)
            $display("FAIL %s: branch_q got %b expected %b", name, bus.branch_q, exp);
        else passed++;
    endtask

    task automatic chk_stall(input string name, input logic exp);
        total++;
        if (bus.not_stall !== exp)
            $display("FAIL %s: not_stall got %b expected %b", name, bus.not_stall, exp);
        else passed++;
    endtask

    task automatic test_reset();
        clear = 1'b0;
        hazard(1'b1, 5'd3, 5'd3, 5'd0);
        drive(3'b000, 4'b0000, 32'h11, 32'h22, 32'h33, 1'b0, 2'b00, 2'b00);
        bus.mem_alu_result = 32'h44; bus.wb_data_d = 32'h55;
        step();
        chk_res("reset_result", 32'h0);
        chk_br("reset_branch", 1'b0);
        total++;
        if (bus.store_data_q !== 32'h0)
            $display("FAIL reset_store: store_data_q got %h expected 0", bus.store_data_q);
        else passed++;
        chk_stall("stall_ignores_clear", 1'b0);
`ifdef EXU_STALL_COUNTER_EN
        total++;
        if (stall_count !== 32'h0)
            $display("FAIL reset_stall_count: got %h expected 0", stall_count);
        else passed++;
`endif
        clear = 1'b1;
    endtask

    task automatic test_stall();
        hazard(1'b1, 5'd5, 5'd5, 5'd0); chk_stall("load_use_rs1", 1'b0);
        hazard(1'b1, 5'd5, 5'd6, 5'd6); chk_stall("no_match", 1'b1);
        hazard(1'b1, 5'd0, 5'd0, 5'd0); chk_stall("rd_zero", 1'b1);
        hazard(1'b1, 5'd7, 5'd1, 5'd7); chk_stall("load_use_rs2", 1'b0);
        hazard(1'b0, 5'd5, 5'd5, 5'd5); chk_stall("not_load", 1'b1);
`ifdef EXU_STALL_COUNTER_EN
        hazard(1'b1, 5'd9, 5'd9, 5'd0);
        step(); step(); step();
        total++;
        if (stall_count !== 32'd3)
            $display("FAIL stall_count: got %h expected 3", stall_count);
        else passed++;
`endif
        hazard(1'b0, 5'd0, 5'd0, 5'd0);
    endtask

    task automatic test_forwarding();
        bus.mem_alu_result = 32'd7; bus.wb_data_d = 32'd9;
        drive(3'b000, 4'b0000, 32'd1, 32'd0, 32'd2, 1'b1, 2'b10, 2'b00);
        step(); chk_res("fwd_a_mem", 32'd9);
        bus.forward_a = 2'b01; step(); chk_res("fwd_a_wb", 32'd11);
        bus.forward_a = 2'b00; step(); chk_res("fwd_a_id", 32'd3);
        bus.forward_a = 2'b11; step(); chk_res("fwd_a_11", 32'd3);
        drive(3'b000, 4'b0000, 32'd1, 32'd100, 32'd2, 1'b0, 2'b00, 2'b01);
        step(); chk_res("fwd_b_wb", 32'd10);
    endtask

    task automatic test_branch();
        drive(3'b001, 4'b0001, 32'd1, 32'd2, 32'd0, 1'b0, 2'b00, 2'b00);
        step(); chk_br("bne", 1'b1); chk_res("branch_sub", 32'hFFFFFFFF);
        bus.func = 4'b0000; step(); chk_br("beq", 1'b0);
        bus.ex_data_a = 32'hFFFFFFFF; bus.ex_data_b = 32'd1;
        bus.func = 4'b0110; step(); chk_br("bltu", 1'b0);
        bus.func = 4'b0100; step(); chk_br("blt", 1'b1);
        bus.func = 4'b0111; step(); chk_br("bgeu", 1'b1);
        bus.func = 4'b0101; step(); chk_br("bge", 1'b0);
        bus.func = 4'b0010; step(); chk_br("f3_010", 1'b0);
        bus.ex_data_b = 32'hFFFFFFFF; bus.func = 4'b0000; step(); chk_br("beq_true", 1'b1);
        bus.alu_op = 3'b010; step(); chk_br("rtype_no_branch", 1'b0);
    endtask

    task automatic test_alu();
        drive(3'b010, 4'b1000, 32'd5, 32'd7, 32'd0, 1'b0, 2'b00, 2'b00);
        step(); chk_res("sub", 32'hFFFFFFFE);
        drive(3'b010, 4'b1101, 32'h80000000, 32'd4, 32'd0, 1'b0, 2'b00, 2'b00);
        step(); chk_res("sra", 32'hF8000000);
        bus.func = 4'b0101; step(); chk_res("srl", 32'h08000000);
        drive(3'b010, 4'b0001, 32'h1, 32'h24, 32'd0, 1'b0, 2'b00, 2'b00);
        step(); chk_res("sll_shamt5", 32'h10);
        drive(3'b011, 4'b1000, 32'd4, 32'd0, 32'd3, 1'b1, 2'b00, 2'b00);
        step(); chk_res("addi", 32'd7);
        drive(3'b011, 4'b1101, 32'h80000000, 32'd0, 32'd4, 1'b1, 2'b00, 2'b00);
        step(); chk_res("srai", 32'hF8000000);
        drive(3'b010, 4'b0010, 32'hFFFFFFFF, 32'd1, 32'd0, 1'b0, 2'b00, 2'b00);
        step(); chk_res("slt", 32'd1);
        bus.func = 4'b0011; step(); chk_res("sltu", 32'd0);
        drive(3'b010, 4'b0100, 32'hF0F0F0F0, 32'hFF00FF00, 32'd0, 1'b0, 2'b00, 2'b00);
        step(); chk_res("xor", 32'h0FF00FF0);
        bus.func = 4'b0110; step(); chk_res("or", 32'hFFF0FFF0);
        bus.func = 4'b0111; step(); chk_res("and", 32'hF000F000);
        drive(3'b100, 4'b0000, 32'd99, 32'd0, 32'h12345000, 1'b1, 2'b00, 2'b00);
        step(); chk_res("lui", 32'h12345000);
        drive(3'b111, 4'b1000, 32'hFFFFFFFF, 32'd2, 32'd0, 1'b0, 2'b00, 2'b00);
        step(); chk_res("op111_add_wrap", 32'd1); chk_br("op111_branch", 1'b0);
    endtask

    task automatic test_store();
        bus.mem_alu_result = 32'hABCD;
        drive(3'b000, 4'b0000, 32'd1, 32'd77, 32'd5, 1'b1, 2'b00, 2'b10);
        step();
        chk_res("store_addr_uses_imm", 32'd6);
        total++;
        if (bus.store_data_q !== 32'hABCD)
            $display("FAIL store_data: got %h expected 0000abcd", bus.store_data_q);
        else passed++;
    endtask

    task automatic test_back_to_back();
        drive(3'b010, 4'b0000, 32'd10, 32'd20, 32'd0, 1'b0, 2'b00, 2'b00);
        @(posedge clock); #1;
        drive(3'b010, 4'b1000, 32'd10, 32'd20, 32'd0, 1'b0, 2'b00, 2'b00);
        chk_res("b2b_first", 32'd30);
        step(); chk_res("b2b_second", 32'hFFFFFFF6);
        drive(3'b001, 4'b0001, 32'd3, 32'd4, 32'd0, 1'b0, 2'b00, 2'b00);
        clear = 1'b0; step(); clear = 1'b1;
        chk_res("mid_reset_result", 32'h0);
        chk_br("mid_reset_branch", 1'b0);
    endtask

    initial begin
        test_reset();
        test_stall();
        test_forwarding();
        test_branch();
        test_alu();
        test_store();
        test_back_to_back();
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
